// File: rtl/mips_run_monitor.sv
// Run-control and self-check monitor for the MIPS pipeline: sequences CPU reset,
// counts run cycles and watches the data-memory port for a pass/fail signature.
module mips_run_monitor #(
  parameter int unsigned      RESET_CYCLES = 1,
  parameter int unsigned      MAX_CYCLES   = 50,
  parameter int unsigned      ADDR_W       = 32,
  parameter int unsigned      DATA_W       = 32,
  parameter int unsigned      CNT_W        = 16,
  parameter longint unsigned  SIG_ADDR     = 84,
  parameter longint unsigned  SIG_DATA     = 7,
  parameter bit               HALT_ON_DONE = 1'b1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              cpu_res,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  write_count,
  output logic [ADDR_W-1:0] last_adr,
  output logic [DATA_W-1:0] last_data
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  localparam logic [ADDR_W-1:0] SIG_ADR_T  = ADDR_W'(SIG_ADDR);
  localparam logic [DATA_W-1:0] SIG_DAT_T  = DATA_W'(SIG_DATA);
  localparam logic [7:0]        HOLD_LAST  = 8'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CYCLE_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] hold_cnt;
  logic       sig_write;
  logic       next_terminal;

  assign sig_write = memwrite && (dataadr == SIG_ADR_T);

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= S_HOLD;
    else     state <= next_state;
  end

  // Signature write is checked before the cycle budget so it wins on the last cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_HOLD: if (hold_cnt == HOLD_LAST) next_state = S_RUN;
      S_RUN: begin
        if (sig_write) next_state = (writedata == SIG_DAT_T) ? S_PASS : S_FAIL;
        else if (cycle_count == CYCLE_LAST) next_state = S_TIMEOUT;
      end
      default: next_state = state;
    endcase
  end

  always_comb begin
    running = 1'b0;
    done    = 1'b0;
    pass    = 1'b0;
    fail    = 1'b0;
    timeout = 1'b0;
    case (state)
      S_RUN:     running = 1'b1;
      S_PASS:    begin done = 1'b1; pass    = 1'b1; end
      S_FAIL:    begin done = 1'b1; fail    = 1'b1; end
      S_TIMEOUT: begin done = 1'b1; timeout = 1'b1; end
      default:   ;
    endcase
  end

  assign next_terminal = (next_state == S_PASS) || (next_state == S_FAIL) ||
                         (next_state == S_TIMEOUT);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cpu_res     <= 1'b1;
      hold_cnt    <= '0;
      cycle_count <= '0;
      write_count <= '0;
      last_adr    <= '0;
      last_data   <= '0;
    end else begin
      cpu_res <= (next_state == S_HOLD) || (next_terminal && HALT_ON_DONE);
      if (state == S_HOLD) hold_cnt <= hold_cnt + 8'd1;
      if (state == S_RUN) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
        if (memwrite) begin
          last_adr  <= dataadr;
          last_data <= writedata;
          if (!sig_write && write_count != '1) write_count <= write_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mips_run_monitor.md
# mips_run_monitor

Synthesizable run-control and self-check monitor for the MIPS 5-stage pipeline CPU. It owns the CPU's reset sequencing, counts execution cycles, and watches the data-memory write port for a pass/fail signature write. It declares TIMEOUT if no signature arrives within a cycle budget. It sits beside the CPU top level in simulation and FPGA bring-up, and replaces fixed-delay reset and stop logic with parametrised, observable status.

## Interface
Parameters:
- RESET_CYCLES, 1: cycles `cpu_res` stays high after `res` deasserts; legal range 1..255.
- MAX_CYCLES, 50: run-cycle budget before TIMEOUT; must be ≥1 and < 2^CNT_W.
- ADDR_W, 32: data-memory address width.
- DATA_W, 32: data-memory write-data width.
- CNT_W, 16: width of both counters.
- SIG_ADDR, 84: signature address.
- SIG_DATA, 7: value that means pass.
- HALT_ON_DONE, 1: when 1, `cpu_res` is reasserted in terminal states to freeze the CPU.

Ports:
- clk, in, 1: the single clock; all logic is rising-edge.
- res, in, 1: asynchronous, active-high reset.
- memwrite, in, 1: CPU data-memory write enable (M stage).
- dataadr, in, ADDR_W: CPU data-memory address.
- writedata, in, DATA_W: CPU data-memory write data.
- cpu_res, out, 1: reset driven to the CPU; registered.
- running, out, 1: high in the RUN state.
- done, out, 1: high in any terminal state.
- pass, out, 1: high in PASS.
- fail, out, 1: high in FAIL.
- timeout, out, 1: high in TIMEOUT.
- cycle_count, out, CNT_W: number of RUN cycles elapsed.
- write_count, out, CNT_W: number of non-signature writes seen in RUN.
- last_adr, out, ADDR_W: address of the most recent write captured in RUN.
- last_data, out, DATA_W: data of the most recent write captured in RUN.

## Operation
- States: HOLD, RUN, PASS, FAIL, TIMEOUT. Encoding is free; all status outputs are decoded from registered state.
- `res` high (asynchronous): state = HOLD, `cpu_res` = 1, hold counter = 0, all counters and last_* = 0, all flags = 0.
- HOLD: the hold counter increments each cycle. When the counter reaches RESET_CYCLES-1, the next state is RUN and `cpu_res` goes to 0 on the same edge.
- RUN: `cycle_count` increments every cycle. The write port is sampled only when `memwrite` = 1.
  - Signature address with `writedata` == SIG_DATA: next state PASS.
  - Signature address with any other data: next state FAIL.
  - Any other address: `write_count` increments.
  - Every sampled write (signature or not) updates last_adr and last_data.
  - No signature write and `cycle_count` == MAX_CYCLES-1: next state TIMEOUT.
- Priority on the same cycle: a signature write beats the timeout. FAIL and PASS cannot coincide.
- Terminal states (PASS, FAIL, TIMEOUT):
  - Sticky until `res`.
  - Counters and last_* freeze.
  - Writes are ignored.
  - `cpu_res` = HALT_ON_DONE.
- `write_count` and `cycle_count` saturate at all-ones. They never wrap.
- Address and data compares are full width. SIG_ADDR and SIG_DATA are truncated to ADDR_W and DATA_W.
- `memwrite` in HOLD is ignored.

## Timing
- Reset values: `cpu_res` = 1; running, done, pass, fail and timeout = 0; cycle_count, write_count, last_adr and last_data = 0.
- Reset entry is asynchronous. Exit from HOLD is synchronous: `res` falls, then after RESET_CYCLES rising edges `cpu_res` = 0 and `running` = 1 together.
- `cycle_count` reads 1 after the first RUN edge.
- Signature detection latency is 1 cycle: the write is sampled on edge N, and pass/fail/done are high after edge N. With HALT_ON_DONE = 1, `cpu_res` also rises after edge N.
- Timeout latency: `timeout` rises on the edge where `cycle_count` becomes MAX_CYCLES, i.e. after exactly MAX_CYCLES RUN edges.
- `res` asserted mid-RUN or in a terminal state: everything clears immediately, without waiting for a clock edge. A full HOLD sequence follows.
- `res` glitch shorter than one cycle: the full HOLD is still applied.

## Test plan
- Reset sequencing, RESET_CYCLES = 3: release `res`. Expect `cpu_res` high for exactly 3 edges, then `cpu_res` = 0 and `running` = 1 on the same edge, and `cycle_count` = 1 one edge later.
- Pass: after 20 RUN cycles drive memwrite = 1, dataadr = 84, writedata = 7 for one cycle. Expect pass = done = 1 and cpu_res = 1 on the next edge; cycle_count frozen at 21; last_adr = 84, last_data = 7.
- Fail, with interleaved writes: writes to 80 (value 5) and 88 (value 9), then address 84 with data 6. Expect fail = 1, write_count = 2, last_data = 6.
- Timeout, MAX_CYCLES = 50, no writes: expect timeout = 1 after exactly 50 RUN edges and cycle_count = 50. A later write to 84/7 is ignored and pass stays 0.
- Boundary: signature write 84/7 on RUN cycle 50 with MAX_CYCLES = 50. Expect pass = 1 and timeout = 0.
- Async reset mid-RUN at cycle 10, then HALT_ON_DONE = 0 rerun: expect immediate cpu_res = 1 and all counters 0 before any edge. After a pass, expect cpu_res = 0 while done = 1.
